uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
- Parametrised successor to the team's fixed 8N1 Bluetooth UART receiver.
- Configurable data width, parity mode and stop-bit count.
- Adds an input synchroniser, 3-sample majority vote, parity/framing error flags and break detection.
- Sits between the Bluetooth module's TX pin and the command parser; the parser consumes o_RX_Byte on o_RX_DV.

Parameters:
- CLKS_PER_BIT, 10400, clock cycles per bit (f_clk / baud); legal values are >= 8.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- i_Clock  in  1  system clock; all logic on its rising edge.
- i_Reset  in  1  synchronous reset, active-high.
- i_RX_Serial  in  1  asynchronous serial line; idles high.
- o_RX_DV  out  1  one-cycle pulse: frame complete, outputs below valid.
- o_RX_Byte  out  DATA_BITS  received data, LSB first on the line.
- o_Parity_Err  out  1  parity mismatch on the last frame; forced 0 when PARITY_MODE = 0.
- o_Frame_Err  out  1  at least one stop bit sampled low on the last frame.
- o_Break  out  1  last frame was a break condition.
- o_Busy  out  1  high whenever the state machine is not in IDLE.

Behaviour:
- Reset and clocking: one clock. Reset is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - Synchroniser flops and the vote shift register reset to 1, so no false start is seen after reset.
  - State = IDLE; counters = 0.
- Input path:
  - Two-flop synchroniser, then a 3-deep shift register.
  - vote = majority of the 3 registered samples.
  - Every decision below uses vote, never the raw input.
- Definitions: H = (CLKS_PER_BIT-1)/2 (integer division). The counter is wide enough to hold CLKS_PER_BIT-1.
- States and transitions:
  - IDLE: counter = 0, bit index = 0. If vote == 0, go to START.
  - START: counter increments each cycle. At counter == H:
    - if vote == 0, clear the counter and go to DATA;
    - otherwise it is a glitch: return to IDLE with no flags and no o_RX_DV.
  - DATA: counter runs 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1:
    - shift reg[bit_index] <= vote and clear the counter;
    - after bit DATA_BITS-1, go to PARITY if PARITY_MODE != 0, else go to STOP.
  - PARITY: same timing as DATA; sample one bit.
    - Odd mode: error if XOR(data, parity bit) != 1.
    - Even mode: error if that XOR != 0.
  - STOP: same timing; sample STOP_BITS bits. Any sample == 0 sets the frame error.
    - In the cycle after the last stop sample: o_RX_DV = 1, and all of o_RX_Byte and the three flags update together.
    - Then go to CLEANUP.
  - CLEANUP: one cycle, o_RX_DV = 0.
    - If o_Break is set, go to WAIT_HIGH; otherwise go to IDLE.
  - WAIT_HIGH: stay until vote == 1, then go to IDLE. This prevents the held-low line from retriggering frames.
- Break: frame error AND all data bits 0 AND parity bit (if present) 0.
  - Reported as o_Break = 1, o_Frame_Err = 1, o_RX_Byte = 0.
  - o_Parity_Err reflects the normal parity check.
- Output hold: o_RX_Byte and all flags hold their values until the next o_RX_DV. They are not cleared by CLEANUP.
- Timing: each sample point falls CLKS_PER_BIT cycles after the previous one, with the first data sample CLKS_PER_BIT cycles after the START decision. There is no cumulative drift.
- Reset mid-frame: an in-progress frame is abandoned with no o_RX_DV. Reset takes priority over every transition.
- A new start bit is accepted in the first IDLE cycle after CLEANUP, so back-to-back frames with 1 stop bit must be received without loss.

Test Plan (CLKS_PER_BIT = 16 unless stated):
- 8N1, send 0xA5 then immediately 0x3C -> two o_RX_DV pulses, bytes 0xA5 then 0x3C, all flags 0.
- 8E1, send 0x07 with parity bit 1 (correct) -> o_RX_DV with o_Parity_Err = 0. Resend with parity bit 0 -> o_RX_DV with o_Parity_Err = 1 and o_RX_Byte = 0x07.
- 8N2, second stop bit driven low -> o_RX_DV with o_Frame_Err = 1, o_Break = 0, byte correct.
- 8N1, line held low for 20 bit times -> exactly one o_RX_DV with o_Break = 1, o_Frame_Err = 1, byte 0x00. No further DV until the line returns high and a valid frame 0x55 is then received correctly.
- Start-bit glitch: line low for 3 cycles then high -> return to IDLE, no o_RX_DV, o_Busy drops within H+4 cycles.
- DATA_BITS = 7, PARITY_MODE = 1: send 0x41 -> o_RX_Byte = 7'h41, parity OK. Assert i_Reset during the bit-3 sample -> no DV, all outputs 0, and the next frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: N data bits, optional odd/even parity, 1 or 2 stop bits.
// The line is synchronised and majority-voted before use, and break frames are flagged.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 10400,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfCnt  = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] LastCnt  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LastStop = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StCleanup,
    StWaitHigh
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [2:0]           samp_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_q, perr_d;
  logic                 frerr_q, frerr_d;
  logic                 brk_q, brk_d;
  logic                 busy_q, busy_d;

  logic vote;
  logic bit_tick;
  logic par_xor;
  logic par_err;
  logic stop_ferr;
  logic is_break;

  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign bit_tick = (cnt_q == LastCnt);

  assign par_xor = (^shift_q) ^ par_bit_q;
  always_comb begin
    par_err = 1'b0;
    if (PARITY_MODE == 1) begin
      par_err = ~par_xor;
    end else if (PARITY_MODE == 2) begin
      par_err = par_xor;
    end
  end

  // Frame error including the stop sample being taken this cycle.
  assign stop_ferr = ferr_acc_q | ~vote;
  assign is_break  = stop_ferr && (shift_q == '0) && ((PARITY_MODE == 0) || !par_bit_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    ferr_acc_d = ferr_acc_q;
    dv_d       = 1'b0;
    byte_d     = byte_q;
    perr_d     = perr_q;
    frerr_d    = frerr_q;
    brk_d      = brk_q;

    unique case (state_q)
      StIdle: begin
        cnt_d      = '0;
        idx_d      = '0;
        par_bit_d  = 1'b0;
        ferr_acc_d = 1'b0;
        if (!vote) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          state_d = vote ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_tick) begin
          cnt_d   = '0;
          // LSB arrives first, so shifting in at the top leaves it in bit 0.
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (idx_q == LastData) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != 0) ? StParity : StStop;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (bit_tick) begin
          cnt_d     = '0;
          par_bit_d = vote;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_tick) begin
          cnt_d      = '0;
          ferr_acc_d = stop_ferr;
          if (idx_q == LastStop) begin
            idx_d   = '0;
            dv_d    = 1'b1;
            byte_d  = shift_q;
            perr_d  = par_err;
            frerr_d = stop_ferr;
            brk_d   = is_break;
            state_d = StCleanup;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCleanup: begin
        state_d = brk_q ? StWaitHigh : StIdle;
      end
      StWaitHigh: begin
        if (vote) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      samp_q     <= 3'b111;
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      dv_q       <= 1'b0;
      byte_q     <= '0;
      perr_q     <= 1'b0;
      frerr_q    <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= i_RX_Serial;
      sync2_q    <= sync1_q;
      samp_q     <= {samp_q[1:0], sync2_q};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      ferr_acc_q <= ferr_acc_d;
      dv_q       <= dv_d;
      byte_q     <= byte_d;
      perr_q     <= perr_d;
      frerr_q    <= frerr_d;
      brk_q      <= brk_d;
      busy_q     <= busy_d;
    end
  end

  assign o_RX_DV      = dv_q;
  assign o_RX_Byte    = byte_q;
  assign o_Parity_Err = perr_q;
  assign o_Frame_Err  = frerr_q;
  assign o_Break      = brk_q;
  assign o_Busy       = busy_q;

endmodule
